// File: rtl/mult_pp_accumulator.sv
// Partial-product accumulator for the 8x8 multiplier array.
// Combines eight 16-bit lane products into 8b/16b lane results or a 32x32 product
// built over two passes, and hands the 64-bit result to writeback via valid/ready.
// Optional feature macro: PPACC_PERF_CNT_EN adds a 32-bit output-transfer counter (perf_cnt).
module mult_pp_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned RES_W  = 4 * PROD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sew,
  input  logic              count_0,
  input  logic [PROD_W-1:0] prod1,
  input  logic [PROD_W-1:0] prod2,
  input  logic [PROD_W-1:0] prod3,
  input  logic [PROD_W-1:0] prod4,
  input  logic [PROD_W-1:0] prod5,
  input  logic [PROD_W-1:0] prod6,
  input  logic [PROD_W-1:0] prod7,
  input  logic [PROD_W-1:0] prod8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic [1:0]        out_sew,
  output logic              err
`ifdef PPACC_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cnt
`endif
);

  localparam int unsigned LaneW = RES_W / 2;
  localparam int unsigned ByteSh = PROD_W / 2;

  typedef enum logic [1:0] {StIdle, StHalf, StFull} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [RES_W-1:0]   r_acc, w_acc_nxt;
  logic [RES_W-1:0]   r_result, w_result_nxt;
  logic [1:0]         r_sew, w_sew_nxt;
  logic               r_err, w_err_nxt;
  logic               w_accept, w_drain;
  logic [LaneW-1:0]   w_lane0, w_lane1;
  logic [RES_W-1:0]   w_pass;

  // Zero-extend one product to result width.
  function automatic logic [RES_W-1:0] ext(input logic [PROD_W-1:0] p);
    logic [RES_W-1:0] e;
    e = '0;
    e[PROD_W-1:0] = p;
    return e;
  endfunction

  // 16x16 from four byte products: AlBl + (AlBh + AhBl)<<8 + AhBh<<16.
  function automatic logic [LaneW-1:0] lane_sum(input logic [PROD_W-1:0] p1,
                                                input logic [PROD_W-1:0] p2,
                                                input logic [PROD_W-1:0] p3,
                                                input logic [PROD_W-1:0] p4);
    logic [LaneW-1:0] e1, e2, e3, e4;
    e1 = '0; e2 = '0; e3 = '0; e4 = '0;
    e1[PROD_W-1:0] = p1;
    e2[PROD_W-1:0] = p2;
    e3[PROD_W-1:0] = p3;
    e4[PROD_W-1:0] = p4;
    return e1 + ((e2 + e3) << ByteSh) + (e4 << PROD_W);
  endfunction

  assign out_valid = (r_state == StFull);
  assign in_ready  = (r_state != StFull) | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;
  assign result    = r_result;
  assign out_sew   = r_sew;
  assign err       = r_err;

  // Combinational lane and pass sums from the current product set.
  always_comb begin
    w_lane0 = lane_sum(prod1, prod2, prod3, prod4);
    w_lane1 = lane_sum(prod5, prod6, prod7, prod8);
    // prod(1+i+4j) weighted by 2^(8(i+j)), j relative to the pass's low B byte.
    w_pass  = ext(prod1)
            + (ext(prod2) << ByteSh)     + (ext(prod3) << (2 * ByteSh))
            + (ext(prod4) << (3 * ByteSh))
            + (ext(prod5) << ByteSh)     + (ext(prod6) << (2 * ByteSh))
            + (ext(prod7) << (3 * ByteSh)) + (ext(prod8) << (4 * ByteSh));
  end

  // Next-state, accumulator and result selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_result_nxt = r_result;
    w_sew_nxt    = r_sew;
    w_err_nxt    = 1'b0;
    case (r_state)
      StIdle, StFull: begin
        // FULL behaves as IDLE in the cycle its result drains.
        if (w_drain) w_state_nxt = StIdle;
        if (w_accept) begin
          case (sew)
            2'b00: begin
              w_result_nxt = {prod4, prod3, prod2, prod1};
              w_sew_nxt    = sew;
              w_state_nxt  = StFull;
            end
            2'b01: begin
              w_result_nxt = {w_lane1, w_lane0};
              w_sew_nxt    = sew;
              w_state_nxt  = StFull;
            end
            2'b10: begin
              if (!count_0) begin
                w_acc_nxt   = w_pass;
                w_state_nxt = StHalf;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      StHalf: begin
        if (w_accept) begin
          w_acc_nxt = '0;
          if (sew == 2'b10 && count_0) begin
            // High-B pass sits two bytes above the low-B pass.
            w_result_nxt = r_acc + (w_pass << (2 * ByteSh));
            w_sew_nxt    = sew;
            w_state_nxt  = StFull;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, accumulator, result and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_result <= '0;
      r_sew    <= 2'b00;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_result <= w_result_nxt;
      r_sew    <= w_sew_nxt;
      r_err    <= w_err_nxt;
    end
  end

`ifdef PPACC_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Count output transfers; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cnt <= '0;
    end else if (w_drain) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_cnt = r_perf_cnt;
`endif

endmodule

// File: doc/mult_pp_accumulator.md
Name: mult_pp_accumulator

Overview:
- Downstream stage of the 8-bit operand slicer; consumes the eight 16-bit products from the 8x8 multiplier array.
- Each product is one lane multiplier's output, i.e. multK_A*multK_B.
- Combines the products into SEW-wide results: 8-bit, 16-bit, or 32-bit across two passes keyed by count_0.
- Presents the 64-bit result to writeback over a valid/ready handshake.

Parameters:
- PROD_W, 16, width of each partial product.
- RES_W, 64, result bus width; fixed at 4*PROD_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  partial-product set valid.
- in_ready  output  1  stage can accept a set.
- sew  input  2  00=8b, 01=16b, 10=32b, 11=reserved.
- count_0  input  1  32b pass select: 0=low-B pass, 1=high-B pass.
- prod1..prod8  input  16 each  unsigned partial products.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  64  combined product.
- out_sew  output  2  SEW tag of result.
- err  output  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, accumulator=0, result=0, out_sew=0, out_valid=0, err=0, in_ready=1.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = (state!=FULL) | out_ready; a same-cycle drain and accept is allowed.
- Operand mapping (upstream convention): A_i, B_j are byte i/j of each 32b operand.
- sew=00:
  - prodK = A_(K-1)*B_(K-1) for K=1..4.
  - result[16k+15:16k] = prod(k+1); prod5..8 ignored.
- sew=01:
  - Lane0: prod1=A0B0, prod2=A0B1, prod3=A1B0, prod4=A1B1.
  - result[31:0] = prod1 + ((prod2+prod3)<<8) + (prod4<<16).
  - Lane1: same formula on prod5..8, into result[63:32].
- sew=10:
  - Pass 0 (count_0=0): prod(1+i+4j) = A_i*B_j for j=0,1.
  - Pass 1 (count_0=1): the same mapping for j=2,3.
  - Each pass adds sum(prod<<8(i+j)) into a 64-bit accumulator.
  - result = accumulator after pass 1.
  - Sums are mod 2^64; no overflow is possible for unsigned 32x32.
- FSM:
  - IDLE:
    - Accept with sew 00/01: compute, register, go FULL.
    - Accept with sew=10, count_0=0: acc=pass0 sum, go HALF.
    - Accept with sew=10, count_0=1: err pulse, set dropped, stay IDLE.
    - Accept with sew=11: err pulse, dropped.
  - HALF:
    - in_ready=1.
    - Accept with sew=10, count_0=1: result=acc+pass1, go FULL.
    - Any other accepted set: err pulse, acc cleared, go IDLE; the offending set is dropped.
  - FULL:
    - out_valid=1; result and out_sew are held stable until the output transfer.
    - On output transfer: go IDLE, or process a simultaneously accepted input per the IDLE rules.
- Latency:
  - sew 00/01: out_valid one cycle after input transfer.
  - sew 10: out_valid one cycle after the pass-1 transfer.
  - Throughput is one result per cycle for 00/01 with out_ready held at 1.
- Reset mid-operation: partial accumulation and any pending result are discarded immediately.
- err is registered, high for exactly one cycle per offending transfer.

Optional Feature:
- Macro: PPACC_PERF_CNT_EN.
- Defined:
  - Adds output perf_cnt[31:0], incremented on each output transfer.
  - Wraps 0xFFFFFFFF→0.
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- sew=00, prod1=0x3AB4 (0x44*0xDD), prod2=0x28A4 (0x33*0xCC), prod3=prod4=0, out_ready=1 → next cycle out_valid=1, result=0x0000_0000_28A4_3AB4, out_sew=00.
- sew=01, prod4=0x0001, prod8=0x0002, others 0 → result=0x0002_0000_0001_0000 after one cycle.
- sew=10 32b, all operands 0xFFFFFFFF:
  - Stimulus: pass 0 (count_0=0) then pass 1 (count_0=1), all prod=0xFE01 in both passes.
  - Response after pass 0: out_valid=0.
  - Response one cycle after pass 1: result=0xFFFF_FFFE_0000_0001.
- Backpressure/protocol errors:
  - out_ready=0 while FULL → result stable and in_ready=0 until out_ready=1.
  - Drain and new accept in the same cycle.
  - sew=10, count_0=1 issued in IDLE → err one-cycle pulse, no out_valid.
- reset asserted while in HALF → in_ready=1, out_valid=0, accumulator cleared; a following fresh pass pair yields the correct result.
- With PPACC_PERF_CNT_EN: perf_cnt=3 after three results.
